instr_fetch_unit: RTL

//  Consumer end of the PC address path in the multi-cycle CPU.

---
 rtl/instr_fetch_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one word read per fetch over req/ack,
// loads the returned word into the IR under IRWre, flags misalign/timeout.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   pc_addr               fetch address from the PC
//   fetch_start           fetch request (accepted in IDLE/ERR)
//   IRWre                 IR write enable from the control unit
//   mem_req, mem_addr     registered read request and address
//   mem_ack, mem_rdata    one-cycle ack with read data
//   ir                    instruction register
//   fetch_busy            state is REQ or HOLD
//   fetch_done            one-cycle pulse after ir is loaded
//   fetch_err, err_code   error flag and code (01 misaligned, 10 timeout)
module instr_fetch_unit #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_addr,
  input  logic          fetch_start,
  input  logic          IRWre,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] ir,
  output logic          fetch_busy,
  output logic          fetch_done,
  output logic          fetch_err,
  output logic [1:0]    err_code
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t        state, state_n;
  logic [7:0]    cnt, cnt_n;
  logic [DW-1:0] data_buf, buf_n;
  logic [DW-1:0] ir_n;
  logic [AW-1:0] addr_n;
  logic          req_n;
  logic          done_n;
  logic          err_n;
  logic [1:0]    code_n;

  assign fetch_busy = (state == REQ) || (state == HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      data_buf   <= '0;
      ir         <= '0;
      mem_addr   <= '0;
      mem_req    <= 1'b0;
      fetch_done <= 1'b0;
      fetch_err  <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      data_buf   <= buf_n;
      ir         <= ir_n;
      mem_addr   <= addr_n;
      mem_req    <= req_n;
      fetch_done <= done_n;
      fetch_err  <= err_n;
      err_code   <= code_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    buf_n   = data_buf;
    ir_n    = ir;
    addr_n  = mem_addr;
    req_n   = mem_req;
    done_n  = 1'b0;
    err_n   = fetch_err;
    code_n  = err_code;
    unique case (state)
      IDLE, ERR: begin
        if (fetch_start) begin
          if (pc_addr[1:0] != 2'b00) begin
            state_n = ERR;
            err_n   = 1'b1;
            code_n  = 2'b01;
          end else begin
            state_n = REQ;
            addr_n  = pc_addr;
            req_n   = 1'b1;
            cnt_n   = '0;
            err_n   = 1'b0;
            code_n  = 2'b00;
          end
        end
      end
      REQ: begin
        // ack has priority over an expiring timeout
        if (mem_ack) begin
          req_n = 1'b0;
          if (IRWre) begin
            ir_n    = mem_rdata;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            buf_n   = mem_rdata;
            state_n = HOLD;
          end
        end else begin
          cnt_n = cnt + 8'd1;
          if (cnt == CNT_LAST) begin
            req_n   = 1'b0;
            state_n = ERR;
            err_n   = 1'b1;
            code_n  = 2'b10;
          end
        end
      end
      HOLD: begin
        if (IRWre) begin
          ir_n    = data_buf;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
